// File: rtl/crank_wheel_gen.sv
// Crank trigger-wheel emulator: generates a VR-style tooth train (default 60-2)
// with a programmable, per-slot ramped period for driving an angle generator.
module crank_wheel_gen #(
    parameter int PERIOD_W   = 16,
    parameter int TEETH_W    = 8,
    parameter int MIN_PERIOD = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [TEETH_W-1:0]  teeth_total,
    input  logic [TEETH_W-1:0]  teeth_missing,
    input  logic [PERIOD_W-1:0] tooth_period,
    input  logic                period_ld,
    input  logic signed [7:0]   period_step,
    output logic                vr_out,
    output logic [TEETH_W-1:0]  tooth_idx,
    output logic                gap,
    output logic                rev_pulse,
    output logic [PERIOD_W-1:0] cur_period,
    output logic                cfg_err
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic signed [PERIOD_W+1:0] MIN_S = MIN_PERIOD;
    localparam logic signed [PERIOD_W+1:0] MAX_S = (1 << PERIOD_W) - 1;

    state_t              state, state_n;
    logic [PERIOD_W-1:0] phase, phase_n, period_n;
    logic [TEETH_W-1:0]  idx_n;
    logic                pending, pending_n;
    logic                cfg_err_n, boundary, run_n;
    logic                vr_n, gap_n, rev_n;
    logic [TEETH_W:0]    tt_ext, tm_ext, idx_ext;

    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        return (p < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : p;
    endfunction

    function automatic logic [PERIOD_W-1:0] step_period(input logic [PERIOD_W-1:0] p,
                                                        input logic signed [7:0] s);
        logic signed [PERIOD_W+1:0] sum;
        sum = $signed({2'b00, p}) + $signed({{(PERIOD_W-6){s[7]}}, s});
        if (sum < MIN_S)
            return PERIOD_W'(MIN_PERIOD);
        else if (sum > MAX_S)
            return '1;
        else
            return sum[PERIOD_W-1:0];
    endfunction

    // Missing slots sit at the top of the index range; config is sampled live.
    function automatic logic is_missing(input logic [TEETH_W-1:0] idx);
        return {1'b0, idx} >= (tt_ext - tm_ext);
    endfunction

    assign tt_ext  = {1'b0, teeth_total};
    assign tm_ext  = {1'b0, teeth_missing};
    assign idx_ext = {1'b0, tooth_idx};

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        idx_n     = tooth_idx;
        period_n  = cur_period;
        pending_n = pending;
        cfg_err_n = (teeth_total < TEETH_W'(3)) || ((tm_ext + (TEETH_W+1)'(1)) >= tt_ext);
        boundary  = (phase >= (cur_period - PERIOD_W'(1)));

        unique case (state)
            IDLE: begin
                phase_n   = '0;
                idx_n     = '0;
                pending_n = 1'b0;
                if (period_ld)
                    period_n = clamp_period(tooth_period);
                if (en && !cfg_err)
                    state_n = RUN;
            end
            RUN: begin
                if (!en || cfg_err) begin
                    state_n   = IDLE;
                    phase_n   = '0;
                    idx_n     = '0;
                    pending_n = 1'b0;
                    if (period_ld)
                        period_n = clamp_period(tooth_period);
                end else if (boundary) begin
                    phase_n   = '0;
                    // Also catches an index stranded above a freshly reduced teeth_total.
                    idx_n     = ((idx_ext + (TEETH_W+1)'(1)) >= tt_ext) ? '0 : tooth_idx + TEETH_W'(1);
                    period_n  = (pending || period_ld) ? clamp_period(tooth_period)
                                                       : step_period(cur_period, period_step);
                    pending_n = 1'b0;
                end else begin
                    phase_n   = phase + PERIOD_W'(1);
                    pending_n = pending | period_ld;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are derived from next-state values so they line up with the registered counters.
        run_n = (state_n == RUN);
        gap_n = run_n && is_missing(idx_n);
        vr_n  = run_n && !is_missing(idx_n) && (phase_n >= (period_n >> 1));
        rev_n = run_n && (idx_n == '0) && (phase_n == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase      <= '0;
            tooth_idx  <= '0;
            cur_period <= PERIOD_W'(MIN_PERIOD);
            pending    <= 1'b0;
            cfg_err    <= 1'b0;
            vr_out     <= 1'b0;
            gap        <= 1'b0;
            rev_pulse  <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            tooth_idx  <= idx_n;
            cur_period <= period_n;
            pending    <= pending_n;
            cfg_err    <= cfg_err_n;
            vr_out     <= vr_n;
            gap        <= gap_n;
            rev_pulse  <= rev_n;
        end
    end

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Scoreboard bench for crank_wheel_gen: a slot-level wheel model predicts every
// clock's outputs, a monitor compares them against the DUT.
module tb_crank_wheel_gen;

    localparam int PW  = 10;
    localparam int TW  = 8;
    localparam int MINP = 2;
    localparam int MAXP = (1 << PW) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [TW-1:0]        teeth_total;
    logic [TW-1:0]        teeth_missing;
    logic [PW-1:0]        tooth_period;
    logic                 period_ld;
    logic signed [7:0]    period_step;
    logic                 vr_out;
    logic [TW-1:0]        tooth_idx;
    logic                 gap;
    logic                 rev_pulse;
    logic [PW-1:0]        cur_period;
    logic                 cfg_err;

    crank_wheel_gen #(.PERIOD_W(PW), .TEETH_W(TW), .MIN_PERIOD(MINP)) dut (
        .clk(clk), .rst(rst), .en(en),
        .teeth_total(teeth_total), .teeth_missing(teeth_missing),
        .tooth_period(tooth_period), .period_ld(period_ld), .period_step(period_step),
        .vr_out(vr_out), .tooth_idx(tooth_idx), .gap(gap), .rev_pulse(rev_pulse),
        .cur_period(cur_period), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vr;
        int idx;
        bit gap;
        bit rev;
        int per;
        bit cfg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Wheel model: running flag, slot number, clocks elapsed in slot, slot length.
    bit m_run = 0;
    int m_pos = 0;
    int m_slot = 0;
    int m_len = MINP;
    bit m_pend = 0;
    bit m_cfg = 0;

    function automatic int clampi(int p);
        return (p < MINP) ? MINP : p;
    endfunction

    function automatic int sati(int p);
        if (p < MINP) return MINP;
        if (p > MAXP) return MAXP;
        return p;
    endfunction

    task automatic model_step();
        int   tt;
        int   tm;
        int   tp;
        bit   old_cfg;
        bit   miss;
        exp_t e;
        tt = int'(teeth_total);
        tm = int'(teeth_missing);
        tp = clampi(int'(tooth_period));
        if (!rst) begin
            m_run = 0; m_pos = 0; m_slot = 0; m_len = MINP; m_pend = 0; m_cfg = 0;
        end else begin
            old_cfg = m_cfg;
            m_cfg   = (tt < 3) || (tm >= tt - 1);
            if (!m_run) begin
                if (period_ld) m_len = tp;
                m_pend = 0;
                if (en && !old_cfg) m_run = 1;
            end else if (!en || old_cfg) begin
                m_run = 0; m_pos = 0; m_slot = 0; m_pend = 0;
                if (period_ld) m_len = tp;
            end else if (m_pos + 1 == m_len) begin
                m_pos  = 0;
                m_slot = (m_slot + 1 >= tt) ? 0 : m_slot + 1;
                m_len  = (m_pend || period_ld) ? tp : sati(m_len + int'(period_step));
                m_pend = 0;
            end else begin
                m_pos  = m_pos + 1;
                m_pend = m_pend | period_ld;
            end
        end
        miss  = (m_slot >= tt - tm);
        e.vr  = m_run && !miss && (m_pos >= m_len / 2);
        e.gap = m_run && miss;
        e.rev = m_run && (m_slot == 0) && (m_pos == 0);
        e.idx = m_slot;
        e.per = m_len;
        e.cfg = m_cfg;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (vr_out !== e.vr || int'(tooth_idx) != e.idx || gap !== e.gap ||
                    rev_pulse !== e.rev || int'(cur_period) != e.per || cfg_err !== e.cfg) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL outputs cycle %0d: got vr=%0b idx=%0d gap=%0b rev=%0b per=%0d cfg=%0b, want vr=%0b idx=%0d gap=%0b rev=%0b per=%0d cfg=%0b",
                                 cycle, vr_out, tooth_idx, gap, rev_pulse, cur_period, cfg_err,
                                 e.vr, e.idx, e.gap, e.rev, e.per, e.cfg);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; en = 1'b1; teeth_total = 8'd60; teeth_missing = 8'd2;
        tooth_period = '0; period_ld = 1'b0; period_step = 8'sd0;
        @(negedge clk);
        run(3);

        // Load 128 in IDLE, then full 60-2 revolutions at constant period.
        rst = 1'b1; en = 1'b0; tooth_period = PW'(128); period_ld = 1'b1;
        tick();
        period_ld = 1'b0;
        tick();
        en = 1'b1;
        run(2 * 7680 + 100);

        // Acceleration down to the minimum period.
        period_step = -8'sd1;
        run(9000);

        // Deceleration into the upper saturation limit.
        en = 1'b0; tooth_period = PW'(1020); period_ld = 1'b1;
        tick();
        period_ld = 1'b0; en = 1'b1; period_step = 8'sd1;
        run(5200);

        // Mid-slot load: the current slot completes at its old length.
        period_step = 8'sd0;
        run(300);
        tooth_period = PW'(40); period_ld = 1'b1;
        tick();
        period_ld = 1'b0;
        run(1200);

        // Illegal configuration halts, legal configuration restarts at slot 0.
        teeth_missing = 8'd59;
        run(50);
        teeth_missing = 8'd2;
        run(200);

        // Odd period, then async reset asserted between clock edges.
        tooth_period = PW'(5); period_ld = 1'b1;
        tick();
        period_ld = 1'b0;
        run(37);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (vr_out !== 1'b0 || tooth_idx !== '0 || gap !== 1'b0 || rev_pulse !== 1'b0 ||
            int'(cur_period) != MINP || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got vr=%0b idx=%0d gap=%0b rev=%0b per=%0d cfg=%0b, want 0 0 0 0 %0d 0",
                     vr_out, tooth_idx, gap, rev_pulse, cur_period, cfg_err, MINP);
        end
        tick();
        rst = 1'b1; en = 1'b0; teeth_total = 8'd6; teeth_missing = 8'd1;
        tooth_period = PW'(6); period_ld = 1'b1;
        tick();
        period_ld = 1'b0; en = 1'b1;

        // Randomized operation on short wheels.
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 199) == 0) en = ~en;
            period_ld = ($urandom_range(0, 29) == 0);
            tooth_period = PW'($urandom_range(0, 12));
            if ($urandom_range(0, 49) == 0) period_step = 8'($signed($urandom_range(0, 4)) - 2);
            if ($urandom_range(0, 299) == 0) begin
                teeth_total   = TW'($urandom_range(2, 12));
                teeth_missing = TW'($urandom_range(0, int'(teeth_total)));
            end
            if (int'(cur_period) > 40 && period_step > 0) period_step = -8'sd2;
            rst = ($urandom_range(0, 1999) != 0);
            tick();
        end
        rst = 1'b1; period_ld = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crank_wheel_gen.md
Name: crank_wheel_gen

Overview:
- Synthesizable crank trigger-wheel emulator. Produces the VR tooth signal that the hwag angle-generator receives on vr_in.
- Default wheel is 60-2: 58 physical teeth followed by a gap of 2 missing teeth.
- Tooth period is programmable and can be ramped per tooth to emulate acceleration or deceleration.
- Used for bench and in-system self-test of hwag; output connects directly to hwag vr_in.

Parameters:
PERIOD_W, 16, width of tooth period and phase counter
TEETH_W, 8, width of tooth count and tooth index
MIN_PERIOD, 2, smallest legal slot period in clocks

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous assert, active-low (0 = reset)
en  in  1  run enable
teeth_total  in  TEETH_W  slots per revolution, including missing slots (e.g. 60)
teeth_missing  in  TEETH_W  missing slots at the end of a revolution (e.g. 2)
tooth_period  in  PERIOD_W  period value loaded by period_ld, in clocks per slot
period_ld  in  1  one-cycle strobe: load tooth_period
period_step  in  8 signed  added to the active period at each slot boundary
vr_out  out  1  emulated VR tooth signal
tooth_idx  out  TEETH_W  current slot index, 0..teeth_total-1
gap  out  1  current slot is a missing slot
rev_pulse  out  1  one-cycle pulse at the first clock of slot 0
cur_period  out  PERIOD_W  active slot period
cfg_err  out  1  configuration is illegal; generator is halted

Behaviour:
- Reset (rst=0): all registers cleared asynchronously. vr_out=0, tooth_idx=0, gap=0, rev_pulse=0, cfg_err=0, phase=0, cur_period=MIN_PERIOD, pending-load flag cleared.
- cfg_err is registered, updated every clock. It is 1 when:
  - teeth_total < 3, or
  - teeth_missing >= teeth_total-1.
- Configuration checks: teeth_missing=0 is legal and gives a plain wheel with no gap.
- States: IDLE and RUN.
  - IDLE→RUN: en=1 and cfg_err=0. The next clock has phase=0, tooth_idx=0 and rev_pulse=1.
  - RUN→IDLE: en=0 or cfg_err=1. The next clock has phase=0, tooth_idx=0, vr_out=0 and gap=0. cur_period is kept.
- Period loading:
  - period_ld in IDLE: loads tooth_period into cur_period on the next clock.
  - period_ld in RUN: sets a pending flag. The load takes effect at the next slot boundary.
  - tooth_period < MIN_PERIOD is clamped to MIN_PERIOD.
- Slot timing in RUN:
  - phase counts 0..cur_period-1.
  - At phase=cur_period-1 (slot boundary), on the following clock:
    - phase becomes 0;
    - tooth_idx becomes tooth_idx+1, wrapping to 0 when tooth_idx reaches teeth_total-1;
    - cur_period updates (next item).
- cur_period update at each slot boundary:
  - pending load set: cur_period = clamped tooth_period, pending flag cleared, period_step ignored for that boundary;
  - otherwise: cur_period = cur_period + period_step, saturating to MIN_PERIOD..2^PERIOD_W-1.
- Missing slots: slot idx is missing when idx >= teeth_total - teeth_missing. gap equals this condition for the current tooth_idx.
- vr_out:
  - registered, and consistent with the tooth_idx, phase and cur_period visible in the same clock;
  - 1 when RUN, slot not missing, and phase >= cur_period>>1; otherwise 0;
  - each tooth is low for the first floor(P/2) clocks and high for the remaining P-floor(P/2) clocks;
  - odd P gives the longer high half.
- rev_pulse is high exactly during the clock in which tooth_idx=0 and phase=0.
- Config inputs change mid-run:
  - teeth_total and teeth_missing are sampled live.
  - If tooth_idx >= a newly reduced teeth_total, the next boundary wraps to 0.
- period_ld on the same clock as a boundary: the load applies at that boundary.
- Asynchronous reset mid-slot: immediate return to the reset values; no glitch beyond the reset edge.

Test Plan:
- Reset then run: rst=0 for 3 clocks with en=1 → all outputs 0. After release, tooth_period=128 loaded in IDLE, then en=1 → rev_pulse one clock later, vr_out low for 64 clocks then high for 64.
- 60-2 wheel, period 128, step 0:
  - 58 high pulses per revolution;
  - a low run of 64+256=320 clocks around the gap;
  - rev_pulse every 7680 clocks;
  - gap=1 only for tooth_idx 58 and 59.
- Acceleration: period 128, step -1 → each successive slot is 1 clock shorter; saturates at MIN_PERIOD=2 and holds there.
- Deceleration and load: step +1 from 0xFFFE → saturates at 0xFFFF. period_ld with tooth_period=40 mid-slot → the current slot finishes at the old length, the next slot is 40 clocks.
- Illegal config: teeth_total=60, teeth_missing=59 → cfg_err=1, vr_out=0, counters held at 0. Restoring missing=2 → run resumes from slot 0 with rev_pulse.
- en dropped mid-high phase → the next clock has vr_out=0 and tooth_idx=0. Odd period 5 → low 2 clocks, high 3 clocks.
